sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single Wishbone-classic slave port of the SDRAM controller between NPORT bus masters, for example video fetch, CPU instruction fetch and CPU data.
- Arbitrates per access, either fixed-priority for port 0 or round-robin among all ports.
- Registers each winning request into a slave-side holding register, so the controller sees stable address, data, sel and we for the whole access.
- Routes ack and read data back to the owning master. A MAX_HOLD limit stops any one master monopolising the SDRAM.

Parameters:
- AW, 25, address width (bank/row/column address of the SDRAM controller).
- DW, 32, data width.
- NPORT, 3, number of masters (2..4).
- MAX_HOLD, 4, consecutive acks a master may take while another port is requesting; range 1..15.
- PRIO0, 1, 1 = port 0 always wins arbitration; 0 = pure round-robin.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- m_cyc_i  in  NPORT  per-master cycle
- m_stb_i  in  NPORT  per-master strobe
- m_we_i  in  NPORT  per-master write enable
- m_adr_i  in  NPORT*AW  master addresses, port k at [k*AW +: AW]
- m_dat_i  in  NPORT*DW  master write data
- m_sel_i  in  NPORT*4  master byte selects
- m_ack_o  out  NPORT  per-master ack
- m_dat_o  out  DW  read data, broadcast to all masters
- s_cyc_o  out  1  to controller cyc_i
- s_stb_o  out  1  to controller stb_i
- s_we_o  out  1  to controller we_i
- s_adr_o  out  AW  to controller adr_i
- s_dat_o  out  DW  to controller dat_i
- s_sel_o  out  4  to controller sel_i
- s_ack_i  in  1  from controller ack_o
- s_dat_i  in  DW  from controller dat_o
- owner_o  out  clog2(NPORT)  current owner (debug)
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk_i; reset is asynchronous, active-low.
- Reset values, applied immediately while rst_n_i is low and independent of clk_i:
  - state=IDLE, owner=0, rr_last=NPORT-1, hold=0.
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o, s_sel_o all 0.
  - m_ack_o=0, busy_o=0.
- Request: req[k] = m_cyc_i[k] & m_stb_i[k].
- Arbitration (combinational pick):
  - If PRIO0=1 and req[0]=1, the winner is port 0.
  - Otherwise the winner is the first requesting port searching rr_last+1, rr_last+2, ... with wrap modulo NPORT.
- State IDLE:
  - If any req: owner<=winner, rr_last<=winner, hold<=0, latch the winner's adr/dat/sel/we into the s_* registers, s_cyc/s_stb<=1, go to ACCESS.
  - Latency is request in cycle N, s_stb_o high in cycle N+1.
- State ACCESS: s_cyc_o=s_stb_o=1 and the s_* outputs stay constant.
  - m_ack_o[owner] = s_ack_i & m_cyc_i[owner] & m_stb_i[owner] (combinational). All other m_ack_o bits are 0.
  - On s_ack_i: s_stb<=0, s_cyc<=0, hold<=hold+1 (saturating at 15), go to GAP.
  - Owner drops cyc mid-access: the access is completed anyway, because the controller is already committed. The ack is absorbed and not forwarded.
- State GAP: one cycle with s_stb_o=0, which lets the controller return to its idle state.
  - Let other = any req[j] with j != owner.
  - If req[owner] and !(other & hold>=MAX_HOLD): latch the owner's new request, s_cyc/s_stb<=1, go to ACCESS.
  - Else go to IDLE. rr_last=owner there, so a preempted owner ranks last in round-robin. PRIO0=1 makes port 0 an exception: it is never preempted by hold, since it wins the next arbitration again.
- m_dat_o = s_dat_i always; masters qualify it with their own ack.
- Writes: the controller acks before the data is driven to SDRAM. The arbiter holds s_dat_o until GAP regardless.
- No ack ever reaches a master whose cyc is low. The arbiter never asserts s_stb_o in two consecutive accesses without an intervening GAP cycle.
- Reset mid-ACCESS: all outputs take their reset values immediately. The controller is reset by the same system reset.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_GAP=2'd2;
  - a helper function computing the round-robin winner and owner index width.
- One natural sub-module, sdram_arb_pick: purely combinational priority/round-robin winner from req, rr_last and PRIO0, outputting a one-hot grant and an index. Everything else stays in sdram_arbiter.

Test Plan:
- Reset: hold rst_n_i low, toggle requests -> all s_* outputs, m_ack_o and busy_o are 0. Release reset, single read from port 1 at adr 25'h0123456 -> s_stb_o high one cycle after request, s_adr_o=25'h0123456, m_ack_o=3'b010 when s_ack_i pulses, m_dat_o equals the model's s_dat_i.
- Simultaneous requests with PRIO0=0 and ports 0, 1, 2 each issuing one write -> grant order 0, 1, 2. The next round after a port-0 grant starts at port 1.
- PRIO0=1, port 2 streaming reads, port 0 asserts a request mid-stream -> port 0 is granted at the first GAP after hold reaches MAX_HOLD=4, then port 2 resumes.
- Monopoly limit with PRIO0=0, port 1 continuous, port 2 waiting -> exactly 4 port-1 acks, then port 2 gets one access.
- Abort: port 1 drops cyc after s_stb_o rises and before s_ack_i -> s_stb_o stays high until s_ack_i, m_ack_o stays 0, then GAP then IDLE.
- Back-to-back writes from the same port with no competitors -> exactly one s_stb_o-low cycle between accesses, s_dat_o stable across each ACCESS, sel 4'b0011 passed unchanged.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_pkg
// Shared definitions for the SDRAM slave-port arbiter:
//   - FSM state encodings (IDLE / ACCESS / GAP)
//   - owner_w()   : width of an owner index for a given port count
//   - rr_winner() : round-robin search starting after the last winner
// -----------------------------------------------------------------------------
package sdram_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    // The consecutive-ack counter is 4 bits wide and saturates here.
    localparam logic [3:0] HOLD_SAT  = 4'd15;

    // Owner index width; a 2-port arbiter still needs one bit.
    function automatic int owner_w(input int nport);
        return (nport <= 2) ? 1 : $clog2(nport);
    endfunction

    // First requesting port found searching last+1, last+2, ... modulo nport.
    // Returns last when nothing requests; callers qualify with |req.
    function automatic logic [1:0] rr_winner(input logic [3:0] req,
                                             input logic [1:0] last,
                                             input int         nport);
        logic [1:0] win;
        logic       found;
        int         k;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            k = (int'(last) + i) % nport;
            if (i <= nport && !found && req[k]) begin
                win   = 2'(k);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// -----------------------------------------------------------------------------
// sdram_arb_pick
// Combinational winner selection: port 0 first when PRIO0 is set, otherwise
// round-robin starting just after rr_last.
// Ports:
//   req      in   per-port request (cyc & stb)
//   rr_last  in   index of the previous winner
//   grant    out  one-hot winner (all zero when nothing requests)
//   idx      out  winner index
//   any      out  at least one port requests
// -----------------------------------------------------------------------------
module sdram_arb_pick
    import sdram_arbiter_pkg::*;
#(
    parameter int NPORT = 3,
    parameter bit PRIO0 = 1'b1,
    parameter int IW    = owner_w(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [IW-1:0]    rr_last,
    output logic [NPORT-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [1:0] rr_idx;

    always_comb begin
        rr_idx = rr_winner(4'(req), 2'(rr_last), NPORT);
        any    = |req;
        if (PRIO0 && req[0]) begin
            idx = '0;
        end else begin
            idx = IW'(rr_idx);
        end
        grant = '0;
        for (int k = 0; k < NPORT; k++) begin
            grant[k] = any && (idx == IW'(k));
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares the Wishbone-classic slave port of the SDRAM controller between
// NPORT masters. Each winning request is registered into the s_* holding
// registers so the controller sees stable signals for the whole access.
// Ack is routed back to the owning master only; read data is broadcast.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   m_cyc_i/m_stb_i/m_we_i    per-master Wishbone controls
//   m_adr_i/m_dat_i/m_sel_i   per-master fields, port k at [k*W +: W]
//   m_ack_o, m_dat_o          per-master ack, broadcast read data
//   s_*_o, s_ack_i, s_dat_i   controller-side Wishbone port
//   owner_o, busy_o           current owner, FSM not idle
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no access in flight; arbitrate and latch the winner
// ST_ACCESS | s_cyc/s_stb high, waiting for the controller ack
// ST_GAP    | one strobe-low cycle; owner continues or arbitration reopens
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int AW       = 25,
    parameter int DW       = 32,
    parameter int NPORT    = 3,
    parameter int MAX_HOLD = 4,
    parameter bit PRIO0    = 1'b1,
    localparam int IW      = owner_w(NPORT)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NPORT-1:0]    m_cyc_i,
    input  logic [NPORT-1:0]    m_stb_i,
    input  logic [NPORT-1:0]    m_we_i,
    input  logic [NPORT*AW-1:0] m_adr_i,
    input  logic [NPORT*DW-1:0] m_dat_i,
    input  logic [NPORT*4-1:0]  m_sel_i,
    output logic [NPORT-1:0]    m_ack_o,
    output logic [DW-1:0]       m_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [3:0]        s_sel_o,
    input  logic              s_ack_i,
    input  logic [DW-1:0]     s_dat_i,
    output logic [IW-1:0]     owner_o,
    output logic              busy_o
);

    logic [1:0]       state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    rr_last;
    logic [3:0]       hold;

    logic [NPORT-1:0] req;
    logic [NPORT-1:0] win_grant;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic [NPORT-1:0] owner_oh;
    logic [NPORT-1:0] src_oh;
    logic             own_req;
    logic             other_req;
    logic             keep_owner;
    logic             load;
    logic [AW-1:0]    nxt_adr;
    logic [DW-1:0]    nxt_dat;
    logic [3:0]       nxt_sel;
    logic             nxt_we;

    assign req = m_cyc_i & m_stb_i;

    sdram_arb_pick #(
        .NPORT (NPORT),
        .PRIO0 (PRIO0),
        .IW    (IW)
    ) u_pick (
        .req     (req),
        .rr_last (rr_last),
        .grant   (win_grant),
        .idx     (win_idx),
        .any     (win_any)
    );

    always_comb begin
        owner_oh  = '0;
        own_req   = 1'b0;
        other_req = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            owner_oh[k] = (owner == IW'(k));
            if (owner == IW'(k)) begin
                own_req = req[k];
            end else begin
                other_req = other_req | req[k];
            end
        end
        // The owner keeps the port unless someone else waits and it has
        // already used up its share of consecutive acks.
        keep_owner = own_req && !(other_req && (hold >= 4'(MAX_HOLD)));
        load       = ((state == ST_IDLE) && win_any) || ((state == ST_GAP) && keep_owner);
        src_oh     = (state == ST_GAP) ? owner_oh : win_grant;
    end

    // AND-OR mux of the selected master's fields into the holding registers.
    always_comb begin
        nxt_adr = '0;
        nxt_dat = '0;
        nxt_sel = '0;
        nxt_we  = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            if (src_oh[k]) begin
                nxt_adr = nxt_adr | m_adr_i[k*AW +: AW];
                nxt_dat = nxt_dat | m_dat_i[k*DW +: DW];
                nxt_sel = nxt_sel | m_sel_i[k*4 +: 4];
                nxt_we  = nxt_we  | m_we_i[k];
            end
        end
    end

    // An aborted access (owner cyc low) still completes; its ack stays here.
    always_comb begin
        m_ack_o = '0;
        for (int k = 0; k < NPORT; k++) begin
            m_ack_o[k] = (state == ST_ACCESS) && owner_oh[k] && s_ack_i
                         && m_cyc_i[k] && m_stb_i[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            owner   <= '0;
            rr_last <= IW'(NPORT - 1);
            hold    <= '0;
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        owner   <= win_idx;
                        rr_last <= win_idx;
                        hold    <= '0;
                        s_cyc_o <= 1'b1;
                        s_stb_o <= 1'b1;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (s_ack_i) begin
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        if (hold != HOLD_SAT) begin
                            hold <= hold + 4'd1;
                        end
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (keep_owner) begin
                        s_cyc_o <= 1'b1;
                        s_stb_o <= 1'b1;
                        state   <= ST_ACCESS;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    s_cyc_o <= 1'b0;
                    s_stb_o <= 1'b0;
                end
            endcase
        end
    end

    // Holding registers change only when a new access is launched, so write
    // data stays put through ACCESS and GAP even after an early ack.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_sel_o <= '0;
            s_we_o  <= 1'b0;
        end else if (load) begin
            s_adr_o <= nxt_adr;
            s_dat_o <= nxt_dat;
            s_sel_o <= nxt_sel;
            s_we_o  <= nxt_we;
        end
    end

    assign m_dat_o = s_dat_i;
    assign owner_o = owner;
    assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Two arbiters side by side: index 0 has port 0 priority, index 1 is pure
// round-robin. Random masters and a random-latency controller drive both.
// A transaction-level reference predicts grants (pushed to a queue), acks
// and strobe activity; a separate monitor compares at the falling edge.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int AW   = 25;
    localparam int DW   = 32;
    localparam int NP   = 3;
    localparam int MAXH = 4;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [NP-1:0]    m_cyc [2];
    logic [NP-1:0]    m_stb [2];
    logic [NP-1:0]    m_we  [2];
    logic [NP*AW-1:0] m_adr [2];
    logic [NP*DW-1:0] m_dat [2];
    logic [NP*4-1:0]  m_sel [2];
    logic [NP-1:0]    m_ack [2];
    logic [DW-1:0]    m_rdat[2];
    logic             s_cyc [2];
    logic             s_stb [2];
    logic             s_we  [2];
    logic [AW-1:0]    s_adr [2];
    logic [DW-1:0]    s_wdat[2];
    logic [3:0]       s_sel [2];
    logic             s_ack [2];
    logic [DW-1:0]    s_rdat[2];
    logic [1:0]       owner [2];
    logic             busy  [2];

    sdram_arbiter #(.AW(AW), .DW(DW), .NPORT(NP), .MAX_HOLD(MAXH), .PRIO0(1'b1)) u_dut_prio (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m_cyc_i(m_cyc[0]), .m_stb_i(m_stb[0]), .m_we_i(m_we[0]),
        .m_adr_i(m_adr[0]), .m_dat_i(m_dat[0]), .m_sel_i(m_sel[0]),
        .m_ack_o(m_ack[0]), .m_dat_o(m_rdat[0]),
        .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_we_o(s_we[0]),
        .s_adr_o(s_adr[0]), .s_dat_o(s_wdat[0]), .s_sel_o(s_sel[0]),
        .s_ack_i(s_ack[0]), .s_dat_i(s_rdat[0]),
        .owner_o(owner[0]), .busy_o(busy[0])
    );

    sdram_arbiter #(.AW(AW), .DW(DW), .NPORT(NP), .MAX_HOLD(MAXH), .PRIO0(1'b0)) u_dut_rr (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m_cyc_i(m_cyc[1]), .m_stb_i(m_stb[1]), .m_we_i(m_we[1]),
        .m_adr_i(m_adr[1]), .m_dat_i(m_dat[1]), .m_sel_i(m_sel[1]),
        .m_ack_o(m_ack[1]), .m_dat_o(m_rdat[1]),
        .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_we_o(s_we[1]),
        .s_adr_o(s_adr[1]), .s_dat_o(s_wdat[1]), .s_sel_o(s_sel[1]),
        .s_ack_i(s_ack[1]), .s_dat_i(s_rdat[1]),
        .owner_o(owner[1]), .busy_o(busy[1])
    );

    typedef struct {
        int            port;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [3:0]    sel;
        logic          we;
    } acc_t;

    acc_t q0[$];
    acc_t q1[$];
    acc_t cur[2];

    // master-side stimulus state
    bit            act  [2][NP];
    bit            lock [2][NP];
    logic [AW-1:0] f_adr[2][NP];
    logic [DW-1:0] f_dat[2][NP];
    logic [3:0]    f_sel[2][NP];
    logic          f_we [2][NP];

    // reference model
    int            mo_owner[2];
    int            mo_last [2];
    int            mo_hold [2];
    bit            mo_srv  [2];
    bit            mo_pause[2];
    int            lat     [2];
    logic [NP-1:0] exp_ack [2];

    // traffic profile
    int   p_req[NP];
    int   abort_pct;
    int   we_mode;      // 0 random, 1 writes only, 2 reads only
    bit   use_fix_sel;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input int d, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, got, want);
        end
    endtask

    task automatic model_reset(input int d);
        mo_owner[d] = 0;
        mo_last[d]  = NP - 1;
        mo_hold[d]  = 0;
        mo_srv[d]   = 1'b0;
        mo_pause[d] = 1'b0;
        lat[d]      = 0;
        exp_ack[d]  = '0;
        if (d == 0) q0.delete(); else q1.delete();
    endtask

    function automatic int pick(input int d);
        if (d == 0 && act[d][0]) return 0;
        for (int i = 1; i <= NP; i++)
            if (act[d][(mo_last[d] + i) % NP]) return (mo_last[d] + i) % NP;
        return -1;
    endfunction

    task automatic grant(input int d, input int k);
        acc_t a;
        a.port = k;
        a.adr  = f_adr[d][k];
        a.dat  = f_dat[d][k];
        a.sel  = f_sel[d][k];
        a.we   = f_we[d][k];
        if (d == 0) q0.push_back(a); else q1.push_back(a);
        mo_owner[d] = k;
        mo_srv[d]   = 1'b1;
        mo_pause[d] = 1'b0;
        lat[d]      = int'($urandom_range(0, 3));
    endtask

    // one clock edge of the reference, using the inputs seen before the edge
    task automatic model_step(input int d);
        if (mo_srv[d]) begin
            if (s_ack[d]) begin
                mo_srv[d]   = 1'b0;
                mo_pause[d] = 1'b1;
                mo_hold[d]  = (mo_hold[d] >= 15) ? 15 : mo_hold[d] + 1;
            end
        end else if (mo_pause[d]) begin
            int o;
            bit other;
            o     = mo_owner[d];
            other = 1'b0;
            for (int j = 0; j < NP; j++)
                if (j != o && act[d][j]) other = 1'b1;
            if (act[d][o] && !(other && mo_hold[d] >= MAXH)) grant(d, o);
            else mo_pause[d] = 1'b0;
        end else begin
            int w;
            w = pick(d);
            if (w >= 0) begin
                mo_last[d] = w;
                mo_hold[d] = 0;
                grant(d, w);
            end
        end
    endtask

    task automatic new_txn(input int d, input int k);
        act[d][k]   = 1'b1;
        f_adr[d][k] = AW'($urandom);
        f_dat[d][k] = $urandom;
        f_sel[d][k] = use_fix_sel ? 4'b0011 : 4'($urandom);
        f_we[d][k]  = (we_mode == 1) ? 1'b1 : (we_mode == 2) ? 1'b0 : 1'($urandom);
    endtask

    task automatic masters(input int d, input logic [NP-1:0] pre);
        for (int k = 0; k < NP; k++) begin
            if (pre[k]) act[d][k] = 1'b0;
            if (lock[d][k] && !(mo_srv[d] && mo_owner[d] == k)) lock[d][k] = 1'b0;
            if (act[d][k] && mo_srv[d] && mo_owner[d] == k && int'($urandom_range(0, 99)) < abort_pct) begin
                act[d][k]  = 1'b0;
                lock[d][k] = 1'b1;
            end
            if (!act[d][k] && !lock[d][k] && int'($urandom_range(0, 99)) < p_req[k]) new_txn(d, k);
        end
    endtask

    task automatic controller(input int d);
        s_ack[d] = 1'b0;
        if (mo_srv[d]) begin
            if (lat[d] == 0) s_ack[d] = 1'b1;
            else lat[d]--;
        end
        s_rdat[d] = $urandom;
    endtask

    task automatic apply(input int d);
        for (int k = 0; k < NP; k++) begin
            m_cyc[d][k]          = act[d][k];
            m_stb[d][k]          = act[d][k];
            m_we[d][k]           = f_we[d][k];
            m_adr[d][k*AW +: AW] = f_adr[d][k];
            m_dat[d][k*DW +: DW] = f_dat[d][k];
            m_sel[d][k*4 +: 4]   = f_sel[d][k];
        end
    endtask

    task automatic calc_ack(input int d);
        exp_ack[d] = '0;
        if (mo_srv[d] && s_ack[d] && act[d][mo_owner[d]]) exp_ack[d][mo_owner[d]] = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [NP-1:0] pre;
            pre = exp_ack[d];
            if (rst_n_i) model_step(d);
            masters(d, pre);
            controller(d);
            apply(d);
            calc_ack(d);
        end
    endtask

    task automatic set_phase(input int ph);
        abort_pct   = 0;
        we_mode     = 0;
        use_fix_sel = 1'b0;
        case (ph)
            0: p_req = '{0, 0, 0};
            1: begin p_req = '{100, 100, 100}; we_mode = 1; end
            2: begin p_req = '{15, 0, 100};    we_mode = 2; end
            3: p_req = '{0, 100, 100};
            4: begin p_req = '{100, 0, 0};     we_mode = 1; use_fix_sel = 1'b1; end
            5: begin p_req = '{40, 40, 40};    abort_pct = 5; end
            default: begin p_req = '{0, 60, 0}; abort_pct = 30; end
        endcase
        if (ph == 0) begin
            for (int d = 0; d < 2; d++) begin
                act[d][1]   = 1'b1;
                f_adr[d][1] = 25'h0123456;
                f_dat[d][1] = $urandom;
                f_sel[d][1] = 4'hF;
                f_we[d][1]  = 1'b0;
                apply(d);
                calc_ack(d);
            end
        end
    endtask

    // monitor / scoreboard
    initial begin
        bit stb_prev[2];
        stb_prev[0] = 1'b0;
        stb_prev[1] = 1'b0;
        forever begin
            @(negedge clk_i);
            for (int d = 0; d < 2; d++) begin
                check("s_stb",  d, 64'(s_stb[d]), 64'(mo_srv[d]));
                check("s_cyc",  d, 64'(s_cyc[d]), 64'(mo_srv[d]));
                check("busy",   d, 64'(busy[d]),  64'(mo_srv[d] | mo_pause[d]));
                check("owner",  d, 64'(owner[d]), 64'(mo_owner[d]));
                check("m_ack",  d, 64'(m_ack[d]), 64'(exp_ack[d]));
                check("m_dat",  d, 64'(m_rdat[d]), 64'(s_rdat[d]));
                if (!rst_n_i) begin
                    check("rst_adr", d, 64'(s_adr[d]),  64'(0));
                    check("rst_dat", d, 64'(s_wdat[d]), 64'(0));
                    check("rst_sel", d, 64'(s_sel[d]),  64'(0));
                    check("rst_we",  d, 64'(s_we[d]),   64'(0));
                end else if (s_stb[d] && !stb_prev[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL grant_unexpected dut%0d: strobe rose, predicted grants 0", d);
                    end else begin
                        if (d == 0) cur[d] = q0.pop_front();
                        else        cur[d] = q1.pop_front();
                        check("grant_port", d, 64'(owner[d]), 64'(cur[d].port));
                        check("grant_adr",  d, 64'(s_adr[d]),  64'(cur[d].adr));
                        check("grant_dat",  d, 64'(s_wdat[d]), 64'(cur[d].dat));
                        check("grant_sel",  d, 64'(s_sel[d]),  64'(cur[d].sel));
                        check("grant_we",   d, 64'(s_we[d]),   64'(cur[d].we));
                    end
                end else if (s_stb[d]) begin
                    check("hold_adr", d, 64'(s_adr[d]),  64'(cur[d].adr));
                    check("hold_dat", d, 64'(s_wdat[d]), 64'(cur[d].dat));
                    check("hold_sel", d, 64'(s_sel[d]),  64'(cur[d].sel));
                    check("hold_we",  d, 64'(s_we[d]),   64'(cur[d].we));
                end
                stb_prev[d] = s_stb[d];
            end
        end
    end

    // stimulus
    initial begin
        int ph_len[7];
        ph_len = '{20, 300, 300, 300, 200, 800, 200};
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            for (int k = 0; k < NP; k++) begin
                act[d][k]   = 1'b0;
                lock[d][k]  = 1'b0;
                f_adr[d][k] = '0;
                f_dat[d][k] = '0;
                f_sel[d][k] = '0;
                f_we[d][k]  = 1'b0;
            end
            s_ack[d]  = 1'b0;
            s_rdat[d] = '0;
            apply(d);
        end
        set_phase(5);

        // requests toggling while reset is held
        rst_n_i = 1'b0;
        repeat (6) begin
            @(posedge clk_i);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NP; k++)
                    if ($urandom_range(0, 1) == 1) new_txn(d, k); else act[d][k] = 1'b0;
                s_rdat[d] = $urandom;
                apply(d);
            end
        end
        @(posedge clk_i);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NP; k++) act[d][k] = 1'b0;
            apply(d);
        end
        rst_n_i = 1'b1;

        for (int ph = 0; ph < 7; ph++) begin
            set_phase(ph);
            repeat (ph_len[ph]) cycle();
        end

        // asynchronous reset in the middle of an access
        set_phase(2);
        for (int i = 0; i < 50 && !mo_srv[0]; i++) cycle();
        check("reset_setup_access", 0, 64'(s_stb[0]), 64'(1));
        #2;
        rst_n_i = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("async_rst_stb",  d, 64'(s_stb[d]), 64'(0));
            check("async_rst_cyc",  d, 64'(s_cyc[d]), 64'(0));
            check("async_rst_busy", d, 64'(busy[d]),  64'(0));
            check("async_rst_ack",  d, 64'(m_ack[d]), 64'(0));
            check("async_rst_adr",  d, 64'(s_adr[d]), 64'(0));
            model_reset(d);
            for (int k = 0; k < NP; k++) begin
                act[d][k]  = 1'b0;
                lock[d][k] = 1'b0;
            end
            s_ack[d] = 1'b0;
            apply(d);
        end
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        set_phase(5);
        repeat (200) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
